zx_tape_fastload: RTL and testbench

//  Generalised instant tape loader: buffers a downloaded .o/.p image, traps the ROM LOAD routine of the selected

---
 rtl/zx_tape_fastload.sv | 207 ++++++++++++++++++++
 tb/tb_zx_tape_fastload.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_tape_fastload.sv
// zx_tape_fastload: instant tape loader. Buffers a downloaded .o/.p image, traps
// the ROM LOAD routine of the selected model, serves a small wait-loop patch in
// place of ROM bytes and copies the image into main RAM one byte per CPU enable.
module zx_tape_fastload #(
  parameter int                        BUF_AW      = 14,
  parameter int                        NUM_MODELS  = 2,
  parameter logic [16*NUM_MODELS-1:0]  ENTRY_ADDRS = {16'h0347, 16'h0207},
  parameter logic [16*NUM_MODELS-1:0]  END_ADDRS   = {16'h03C3, 16'h024D},
  parameter logic [16*NUM_MODELS-1:0]  RET_ADDRS   = {16'h0207, 16'h0203},
  parameter logic [15:0]               O_BASE      = 16'h4000,
  parameter logic [15:0]               P_BASE      = 16'h4009,
  localparam int                       MW          = (NUM_MODELS > 1) ? $clog2(NUM_MODELS) : 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_cpu,
  input  logic [MW-1:0] model_sel,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [15:0]   cpu_addr,
  input  logic          cpu_nM1,
  output logic          tape_ready,
  output logic          active,
  output logic          patch_hit,
  output logic [7:0]    patch_dout,
  output logic          ram_we,
  output logic [15:0]   ram_addr,
  output logic [7:0]    ram_din,
  output logic          overflow
);

  localparam int              DEPTH   = 2**BUF_AW;
  localparam logic [BUF_AW:0] LEN_MAX = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0] LEN_ONE = {{BUF_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic            dl_prev;
  logic            nm1_prev;
  logic [BUF_AW:0] length;
  logic [BUF_AW:0] n;
  logic [15:0]     base;
  logic [MW-1:0]   model_q;
  logic            vld_p0;
  logic [15:0]     addr_p0;
  logic [7:0]      rd_p0;
  logic [15:0]     entry;
  logic [15:0]     win_end;
  logic [15:0]     ret;
  logic [15:0]     off;

  logic            tape_idx;
  logic            in_range;
  logic            buf_we;
  logic            dl_rise;
  logic            dl_fall;
  logic            m1_evt;
  logic            outside;
  logic [BUF_AW:0] wr_len;
  logic [BUF_AW:0] len_base;

  assign tape_idx = (ioctl_index != 8'h00);
  assign in_range = (ioctl_addr[24:BUF_AW] == '0);
  assign buf_we   = ioctl_wr & tape_idx & in_range;
  assign dl_rise  = ioctl_download & ~dl_prev;
  assign dl_fall  = ~ioctl_download & dl_prev;
  assign m1_evt   = nm1_prev & ~cpu_nM1;
  assign outside  = (cpu_addr >= win_end) || (cpu_addr < entry);
  assign wr_len   = {1'b0, ioctl_addr[BUF_AW-1:0]} + LEN_ONE;
  assign len_base = (dl_rise & tape_idx) ? '0 : length;

  assign ram_we   = vld_p0;
  assign ram_addr = addr_p0;
  assign ram_din  = vld_p0 ? rd_p0 : 8'h00;

  // Pick the trap/return address set of the latched model.
  always_comb begin
    entry   = ENTRY_ADDRS[15:0];
    win_end = END_ADDRS[15:0];
    ret     = RET_ADDRS[15:0];
    for (int m = 0; m < NUM_MODELS; m++) begin
      if (model_q == MW'(m)) begin
        entry   = ENTRY_ADDRS[m*16 +: 16];
        win_end = END_ADDRS[m*16 +: 16];
        ret     = RET_ADDRS[m*16 +: 16];
      end
    end
  end

  // Patch ROM bytes: AF ; NOP/SCF ; JR NC,-3 ; JP ret. The second byte flips
  // to SCF once the copy is done so the wait loop falls through to the JP.
  always_comb begin
    off       = cpu_addr - entry;
    patch_hit = active && (off < 16'd7);
    case (off)
      16'd0:   patch_dout = 8'hAF;
      16'd1:   patch_dout = (state == DONE) ? 8'h37 : 8'h00;
      16'd2:   patch_dout = 8'h30;
      16'd3:   patch_dout = 8'hFD;
      16'd4:   patch_dout = 8'hC3;
      16'd5:   patch_dout = ret[7:0];
      16'd6:   patch_dout = ret[15:8];
      default: patch_dout = 8'hFF;
    endcase
  end

  // Tape buffer write port; out-of-range bytes are dropped.
  always_ff @(posedge clk_sys) begin
    if (buf_we) mem[ioctl_addr[BUF_AW-1:0]] <= ioctl_dout;
  end

  // Tape buffer read port, read address is the copy index.
  always_ff @(posedge clk_sys) begin
    rd_p0 <= mem[n[BUF_AW-1:0]];
  end

  // Image length (highest offset + 1, saturating) and overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      length   <= '0;
      overflow <= 1'b0;
    end else begin
      length <= len_base;
      if (dl_rise & tape_idx) overflow <= 1'b0;
      if (ioctl_wr & tape_idx) begin
        if (!in_range) begin
          overflow <= 1'b1;
          length   <= LEN_MAX;
        end else if (wr_len > len_base) begin
          length <= wr_len;
        end
      end
    end
  end

  // Loader FSM: arm on download end, trap LOAD, copy, release on leaving window.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      tape_ready <= 1'b0;
      active     <= 1'b0;
      n          <= '0;
      vld_p0     <= 1'b0;
      addr_p0    <= '0;
      base       <= O_BASE;
      model_q    <= '0;
      dl_prev    <= 1'b0;
      nm1_prev   <= 1'b1;
    end else begin
      dl_prev  <= ioctl_download;
      nm1_prev <= cpu_nM1;
      vld_p0   <= 1'b0;
      if (state == IDLE || state == ARMED) model_q <= model_sel;
      if (dl_rise && tape_idx) begin
        state      <= IDLE;
        tape_ready <= 1'b0;
        active     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (dl_fall && tape_idx && length != '0) begin
              state      <= ARMED;
              tape_ready <= 1'b1;
              base       <= (ioctl_index[7:6] == 2'b00) ? O_BASE : P_BASE;
            end
          end
          ARMED: begin
            if (m1_evt && cpu_addr == entry) begin
              state  <= COPY;
              n      <= '0;
              active <= 1'b1;
            end
          end
          COPY: begin
            if (m1_evt && outside) begin
              state  <= ARMED;
              active <= 1'b0;
            end else if (n == length) begin
              state <= DONE;
            end else if (ce_cpu) begin
              // stage p0: buffer byte n is being read; write goes out next cycle
              vld_p0  <= 1'b1;
              addr_p0 <= base + 16'(n);
              n       <= n + LEN_ONE;
            end
          end
          DONE: begin
            if (m1_evt && outside) begin
              state  <= ARMED;
              active <= 1'b0;
            end else if (m1_evt && cpu_addr == entry) begin
              state <= COPY;
              n     <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zx_tape_fastload.sv
// Directed bench for zx_tape_fastload: .p/.o loads on both models, patch bytes,
// trap exit/retrap, abort by new download, and buffer overflow.
module tb_zx_tape_fastload;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_cpu = 1'b0;
  logic [0:0]  model_sel = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_nM1 = 1'b1;
  logic        tape_ready, active, patch_hit, ram_we, overflow;
  logic [7:0]  patch_dout, ram_din;
  logic [15:0] ram_addr;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [15:0] wr_addr_log [int];
  logic [7:0]  wr_din_log  [int];
  logic [7:0]  pat [8];

  zx_tape_fastload dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .model_sel(model_sel),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .cpu_addr(cpu_addr),
    .cpu_nM1(cpu_nM1), .tape_ready(tape_ready), .active(active),
    .patch_hit(patch_hit), .patch_dout(patch_dout), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM write log, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (ram_we) begin
      wr_addr_log[wr_cnt] = ram_addr;
      wr_din_log[wr_cnt]  = ram_din;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] log_addr(input int i);
    return wr_addr_log.exists(i) ? wr_addr_log[i] : 16'hxxxx;
  endfunction

  function automatic logic [7:0] log_din(input int i);
    return wr_din_log.exists(i) ? wr_din_log[i] : 8'hxx;
  endfunction

  // bytes come from pat[] for short images, else offset[7:0]
  task automatic download(input logic [7:0] idx, input int cnt);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < cnt; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = (cnt <= 8) ? pat[i] : 8'(i);
      tick(1);
    end
    ioctl_wr = 1'b0;
    tick(1);
    ioctl_download = 1'b0;
    tick(2);
  endtask

  task automatic m1(input logic [15:0] a);
    cpu_addr = a;
    cpu_nM1  = 1'b0;
    tick(1);
    cpu_nM1  = 1'b1;
    tick(1);
  endtask

  logic [7:0] exp_m1 [7] = '{8'hAF, 8'h00, 8'h30, 8'hFD, 8'hC3, 8'h07, 8'h02};
  logic [7:0] exp_m0 [7] = '{8'hAF, 8'h00, 8'h30, 8'hFD, 8'hC3, 8'h03, 8'h02};
  int c0;

  initial begin
    // reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_ready", tape_ready, 0);
    check("rst_active", active, 0);
    check("rst_we", ram_we, 0);
    check("rst_ovf", overflow, 0);
    check("rst_hit", patch_hit, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);

    // .p image 11 22 33 on model 1
    model_sel = 1'b1;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    download(8'h41, 3);
    check("p_ready", tape_ready, 1);
    check("p_active_pre", active, 0);
    m1(16'h0347);
    check("p_active", active, 1);
    model_sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cpu_addr = 16'h0347 + 16'(i);
      #1;
      check($sformatf("p_patch%0d", i), patch_dout, exp_m1[i]);
      check($sformatf("p_hit%0d", i), patch_hit, 1);
    end
    cpu_addr = 16'h034E;
    #1;
    check("p_patch_out", patch_dout, 8'hFF);
    check("p_hit_out", patch_hit, 0);
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(10);
    check("p_wcnt", wr_cnt - c0, 3);
    check("p_a0", log_addr(c0), 16'h4009);
    check("p_d0", log_din(c0), 8'h11);
    check("p_a1", log_addr(c0 + 1), 16'h400A);
    check("p_d1", log_din(c0 + 1), 8'h22);
    check("p_a2", log_addr(c0 + 2), 16'h400B);
    check("p_d2", log_din(c0 + 2), 8'h33);
    cpu_addr = 16'h0348;
    #1;
    check("p_scf", patch_dout, 8'h37);
    check("p_active_done", active, 1);

    // leave window, retrap, exit mid-copy, retrap restarts at n=0
    model_sel = 1'b1;
    m1(16'h03C3);
    check("x_active", active, 0);
    check("x_ready", tape_ready, 1);
    ce_cpu = 1'b0;
    m1(16'h0347);
    check("x_active2", active, 1);
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(1);
    ce_cpu = 1'b0;
    tick(3);
    check("x_onewr", wr_cnt - c0, 1);
    check("x_onewr_a", log_addr(c0), 16'h4009);
    m1(16'h03C3);
    check("x_exit", active, 0);
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(5);
    check("x_armed_nowr", wr_cnt - c0, 0);
    m1(16'h0347);
    tick(10);
    check("x_rewr", wr_cnt - c0, 3);
    check("x_rewr_a", log_addr(c0), 16'h4009);
    check("x_rewr_d", log_din(c0), 8'h11);

    // reset abandons load
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("r_ready", tape_ready, 0);
    check("r_active", active, 0);
    m1(16'h0347);
    check("r_notrap", active, 0);

    // index 0 ignored; .o image AA BB on model 0
    ce_cpu = 1'b0;
    model_sel = 1'b0;
    pat[0] = 8'hAA; pat[1] = 8'hBB;
    download(8'h00, 2);
    check("o_idx0_ready", tape_ready, 0);
    download(8'h01, 2);
    check("o_ready", tape_ready, 1);
    m1(16'h0207);
    check("o_active", active, 1);
    for (int i = 0; i < 7; i++) begin
      cpu_addr = 16'h0207 + 16'(i);
      #1;
      check($sformatf("o_patch%0d", i), patch_dout, exp_m0[i]);
    end
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(8);
    check("o_wcnt", wr_cnt - c0, 2);
    check("o_a0", log_addr(c0), 16'h4000);
    check("o_d0", log_din(c0), 8'hAA);
    check("o_a1", log_addr(c0 + 1), 16'h4001);
    check("o_d1", log_din(c0 + 1), 8'hBB);

    // new download mid-copy aborts
    m1(16'h0100);
    check("a_exit_low", active, 0);
    ce_cpu = 1'b0;
    m1(16'h0207);
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(1);
    ioctl_index    = 8'h41;
    ioctl_download = 1'b1;
    tick(1);
    check("a_ready", tape_ready, 0);
    check("a_active", active, 0);
    check("a_we", ram_we, 0);
    tick(4);
    check("a_wcnt", wr_cnt - c0, 1);
    ioctl_download = 1'b0;
    tick(3);
    check("a_zero_len", tape_ready, 0);

    // overflow: 2**14 + 5 bytes
    ce_cpu = 1'b0;
    model_sel = 1'b1;
    download(8'h41, 16384 + 5);
    check("v_ovf", overflow, 1);
    check("v_ready", tape_ready, 1);
    m1(16'h0347);
    c0 = wr_cnt;
    ce_cpu = 1'b1;
    tick(16400);
    check("v_wcnt", wr_cnt - c0, 16384);
    check("v_first_a", log_addr(c0), 16'h4009);
    check("v_first_d", log_din(c0), 8'h00);
    check("v_last_a", log_addr(c0 + 16383), 16'h8008);
    check("v_last_d", log_din(c0 + 16383), 8'hFF);
    ce_cpu = 1'b0;
    ioctl_download = 1'b1;
    tick(1);
    check("v_ovf_clr", overflow, 0);
    ioctl_download = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
